// File: rtl/ssio_sched_pkg.sv
// ssio_sched_pkg: scheduler state encoding, default link codes and index width helper
package ssio_sched_pkg;
    typedef enum logic [2:0] {IDLE, SOF, XFER, EOF, GAP} state_t;
    localparam int STATE_W = $bits(state_t);
    localparam logic [7:0] DEF_IDLE_CODE = 8'h07;
    localparam logic [7:0] DEF_SOF_CODE = 8'hFB;
    localparam logic [7:0] DEF_EOF_CODE = 8'hFD;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/ssio_tx_rr_arb.sv
// ssio_tx_rr_arb: picks the first requester after the last grant, wrapping at PORTS
module ssio_tx_rr_arb
    import ssio_sched_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int GW = idx_w(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    win,
    output logic             any
);
    logic [GW-1:0] hi, lo;
    logic          hit;
    always_comb begin
        hi = '0;
        lo = '0;
        hit = 1'b0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (req[p]) lo = GW'(p);
            if (req[p] && p > int'(last)) begin
                hi = GW'(p);
                hit = 1'b1;
            end
        end
    end
    assign win = hit ? hi : lo;
    assign any = |req;
endmodule

// File: rtl/ssio_sdr_tx_sched.sv
// ssio_sdr_tx_sched: per-frame round-robin scheduler framing streams onto one SDR link
module ssio_sdr_tx_sched
    import ssio_sched_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int WIDTH = 8,
    parameter int IFG = 2,
    parameter logic [WIDTH-1:0] IDLE_CODE = WIDTH'(DEF_IDLE_CODE),
    parameter logic [WIDTH-1:0] SOF_CODE = WIDTH'(DEF_SOF_CODE),
    parameter logic [WIDTH-1:0] EOF_CODE = WIDTH'(DEF_EOF_CODE),
    localparam int GW = idx_w(PORTS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tx_enable,
    input  logic [PORTS*WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]       s_axis_tvalid,
    output logic [PORTS-1:0]       s_axis_tready,
    input  logic [PORTS-1:0]       s_axis_tlast,
    output logic [WIDTH-1:0]       tx_d,
    output logic                   tx_ctrl,
    output logic                   busy,
    output logic [GW-1:0]          grant,
    output logic                   underflow
);
    localparam int CW = idx_w(IFG + 1);
    state_t           state;
    logic [CW-1:0]    gap_cnt;
    logic [WIDTH-1:0] lane [PORTS];
    logic [GW-1:0]    win;
    logic             any, beat;
    for (genvar i = 0; i < PORTS; i++) begin : g_lane
        assign lane[i] = s_axis_tdata[i*WIDTH +: WIDTH];
    end
    ssio_tx_rr_arb #(.PORTS(PORTS), .GW(GW)) u_arb (
        .req  (s_axis_tvalid),
        .last (grant),
        .win  (win),
        .any  (any)
    );
    assign beat = (state == XFER) && s_axis_tvalid[grant];
    assign s_axis_tready = (state == XFER) ? PORTS'(1) << grant : '0;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            grant <= GW'(PORTS - 1);
            gap_cnt <= '0;
            tx_d <= IDLE_CODE;
            tx_ctrl <= 1'b1;
            underflow <= 1'b0;
        end else begin
            tx_d <= (state == SOF) ? SOF_CODE : (state == EOF) ? EOF_CODE : beat ? lane[grant] : IDLE_CODE;
            tx_ctrl <= !beat;
            underflow <= (state == XFER) && !s_axis_tvalid[grant];
            case (state)
                IDLE: if (tx_enable && any) begin
                    grant <= win;
                    state <= SOF;
                end
                SOF: state <= XFER;
                XFER: if (beat && s_axis_tlast[grant]) state <= EOF;
                EOF: begin
                    gap_cnt <= CW'(IFG > 0 ? IFG - 1 : 0);
                    state <= (IFG == 0) ? IDLE : GAP;
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ssio_sdr_tx_sched.sv
// tb_ssio_sdr_tx_sched: directed frame sequences on the scheduler link output
module tb_ssio_sdr_tx_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_enable = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tvalid = '0;
    logic [3:0]  s_tlast = '0;
    logic [3:0]  tready_a, tready_b;
    logic [7:0]  tx_d_a, tx_d_b;
    logic        tx_ctrl_a, tx_ctrl_b, busy_a, busy_b, uf_a, uf_b;
    logic [1:0]  grant_a, grant_b;
    logic [9:0]  q [4][$];
    logic [3:0]  popq = '0;
    logic        use_b = 1'b0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    ssio_sdr_tx_sched #(.PORTS(4), .WIDTH(8), .IFG(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(tready_a),
        .s_axis_tlast(s_tlast), .tx_d(tx_d_a), .tx_ctrl(tx_ctrl_a),
        .busy(busy_a), .grant(grant_a), .underflow(uf_a)
    );
    ssio_sdr_tx_sched #(.PORTS(4), .WIDTH(8), .IFG(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .tx_enable(tx_enable),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(tready_b),
        .s_axis_tlast(s_tlast), .tx_d(tx_d_b), .tx_ctrl(tx_ctrl_b),
        .busy(busy_b), .grant(grant_b), .underflow(uf_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic lnk(input string tag, input logic [7:0] d, input logic c);
        chk({tag, ".d"}, tx_d_a, d);
        chk({tag, ".c"}, tx_ctrl_a, c);
    endtask

    task automatic lnkb(input string tag, input logic [7:0] d, input logic c);
        chk({tag, ".d"}, tx_d_b, d);
        chk({tag, ".c"}, tx_ctrl_b, c);
    endtask

    // entry = {gap, last, data}; a gap entry holds tvalid low for one cycle
    task automatic push(input int p, input logic [9:0] e);
        q[p].push_back(e);
    endtask

    task automatic src;
        logic [3:0] tr;
        tr = use_b ? tready_b : tready_a;
        for (int p = 0; p < 4; p++) begin
            if (popq[p] && q[p].size() > 0) void'(q[p].pop_front());
            s_tvalid[p] = 1'b0;
            s_tlast[p] = 1'b0;
            popq[p] = 1'b0;
            if (q[p].size() > 0) begin
                s_tvalid[p] = !q[p][0][9];
                s_tlast[p] = q[p][0][8];
                s_tdata[p*8 +: 8] = q[p][0][7:0];
                popq[p] = q[p][0][9] || (s_tvalid[p] && tr[p]);
            end
        end
    endtask

    task automatic cyc;
        @(negedge clk);
        src();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_src;
        for (int p = 0; p < 4; p++) q[p].delete();
        popq = '0;
        s_tvalid = '0;
        s_tlast = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_src();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_a && n < 50) begin
            cyc();
            n++;
        end
        chk(tag, busy_a, 1'b0);
    endtask

    initial begin
        cyc();
        cyc();
        lnk("rst_link", 8'h07, 1'b1);
        chk("rst_tready", tready_a, 4'h0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_uf", uf_a, 1'b0);
        chk("rst_grant", grant_a, 2'd3);
        rst_n = 1'b1;

        // single 3-beat frame from port 0
        push(0, 10'h011); push(0, 10'h022); push(0, 10'h133);
        cyc(); lnk("t1_c1", 8'h07, 1'b1); chk("t1_busy_sof", busy_a, 1'b1); chk("t1_grant", grant_a, 2'd0);
        cyc(); lnk("t1_sof", 8'hFB, 1'b1);
        cyc(); lnk("t1_d0", 8'h11, 1'b0);
        cyc(); lnk("t1_d1", 8'h22, 1'b0);
        cyc(); lnk("t1_d2", 8'h33, 1'b0);
        cyc(); lnk("t1_eof", 8'hFD, 1'b1);
        cyc(); lnk("t1_gap0", 8'h07, 1'b1); chk("t1_busy_gap", busy_a, 1'b1);
        cyc(); lnk("t1_gap1", 8'h07, 1'b1); chk("t1_busy_idle", busy_a, 1'b0);
        cyc(); lnk("t1_idle", 8'h07, 1'b1);

        // round robin across ports 0,1,3 with port 0 refilled mid-way
        do_reset();
        push(0, 10'h1A0); push(1, 10'h1A1); push(3, 10'h1A3);
        for (int k = 1; k <= 21; k++) begin
            cyc();
            if (k == 14) push(0, 10'h1B0);
            if (k == 1) chk("t2_g0", grant_a, 2'd0);
            if (k == 3) lnk("t2_d0", 8'hA0, 1'b0);
            if (k == 7) chk("t2_g1", grant_a, 2'd1);
            if (k == 9) lnk("t2_d1", 8'hA1, 1'b0);
            if (k == 13) chk("t2_g3", grant_a, 2'd3);
            if (k == 15) lnk("t2_d3", 8'hA3, 1'b0);
            if (k == 19) chk("t2_g0b", grant_a, 2'd0);
            if (k == 21) lnk("t2_d0b", 8'hB0, 1'b0);
        end
        wait_idle("t2_idle");

        // underflow: port 2 stalls two cycles mid-frame
        push(2, 10'h0C1); push(2, 10'h0C2); push(2, 10'h200); push(2, 10'h200);
        push(2, 10'h0C3); push(2, 10'h1C4);
        cyc(); chk("t3_grant", grant_a, 2'd2);
        cyc(); lnk("t3_sof", 8'hFB, 1'b1);
        cyc(); lnk("t3_d0", 8'hC1, 1'b0); chk("t3_uf0", uf_a, 1'b0);
        cyc(); lnk("t3_d1", 8'hC2, 1'b0);
        cyc(); lnk("t3_u0", 8'h07, 1'b1); chk("t3_uf1", uf_a, 1'b1);
        cyc(); lnk("t3_u1", 8'h07, 1'b1); chk("t3_uf2", uf_a, 1'b1);
        cyc(); lnk("t3_d2", 8'hC3, 1'b0); chk("t3_uf3", uf_a, 1'b0);
        cyc(); lnk("t3_d3", 8'hC4, 1'b0);
        cyc(); lnk("t3_eof", 8'hFD, 1'b1);
        wait_idle("t3_idle");

        // no pre-emption; tx_enable only gates the next SOF
        push(0, 10'h0D1); push(0, 10'h1D2);
        cyc(); chk("t4_g0", grant_a, 2'd0);
        cyc(); lnk("t4_sof", 8'hFB, 1'b1);
        push(1, 10'h1E1);
        cyc(); lnk("t4_d0", 8'hD1, 1'b0); chk("t4_tready", tready_a, 4'b0001);
        tx_enable = 1'b0;
        cyc(); lnk("t4_d1", 8'hD2, 1'b0);
        cyc(); lnk("t4_eof", 8'hFD, 1'b1);
        cyc(); chk("t4_busy_gap", busy_a, 1'b1);
        cyc(); chk("t4_busy_idle", busy_a, 1'b0);
        cyc();
        cyc();
        cyc(); chk("t4_held", busy_a, 1'b0); chk("t4_held_g", grant_a, 2'd0);
        tx_enable = 1'b1;
        cyc(); chk("t4_g1_busy", busy_a, 1'b1); chk("t4_g1", grant_a, 2'd1);
        cyc(); lnk("t4_sof1", 8'hFB, 1'b1);
        cyc(); lnk("t4_e1", 8'hE1, 1'b0);
        wait_idle("t4_idle");

        // IFG=0 instance: back-to-back frames separated by one idle word
        do_reset();
        use_b = 1'b1;
        push(0, 10'h1F0); push(1, 10'h1F1);
        cyc(); chk("t5_g0", grant_b, 2'd0);
        cyc(); lnkb("t5_sof0", 8'hFB, 1'b1);
        cyc(); lnkb("t5_d0", 8'hF0, 1'b0);
        cyc(); lnkb("t5_eof0", 8'hFD, 1'b1);
        cyc(); lnkb("t5_idle", 8'h07, 1'b1);
        cyc(); lnkb("t5_sof1", 8'hFB, 1'b1); chk("t5_g1", grant_b, 2'd1);
        cyc(); lnkb("t5_d1", 8'hF1, 1'b0);
        cyc(); lnkb("t5_eof1", 8'hFD, 1'b1);
        cyc(); lnkb("t5_after", 8'h07, 1'b1);
        use_b = 1'b0;
        do_reset();

        // asynchronous reset in the middle of a port 1 frame
        push(1, 10'h0A1); push(1, 10'h0A2); push(1, 10'h0A3); push(1, 10'h1A4);
        cyc(); chk("t6_g1", grant_a, 2'd1);
        cyc(); lnk("t6_sof", 8'hFB, 1'b1);
        cyc(); lnk("t6_d0", 8'hA1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6_tready", tready_a, 4'h0);
        lnk("t6_link", 8'h07, 1'b1);
        chk("t6_busy", busy_a, 1'b0);
        chk("t6_grant", grant_a, 2'd3);
        clear_src();
        cyc();
        cyc();
        rst_n = 1'b1;
        push(0, 10'h130); push(2, 10'h132);
        cyc(); chk("t6_regrant", grant_a, 2'd0); chk("t6_busy2", busy_a, 1'b1);
        cyc(); lnk("t6_sof2", 8'hFB, 1'b1);
        cyc(); lnk("t6_j0", 8'h30, 1'b0);
        wait_idle("t6_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
